// File: rtl/pe_fios_seq.sv
// Sequential FIOS Montgomery processing element: one outer iteration
// (fixed a_i) over NWORDS streamed words of b, p and t.
module pe_fios_seq #(
    parameter int WIDTH    = 17,
    parameter int NWORDS   = 8,
    parameter int MULT_LAT = 3
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] p_prime_0_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [WIDTH-1:0] in_p_i,
    input  logic [WIDTH-1:0] in_t_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_t_o,
    output logic             out_top_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int XW = 2 * WIDTH + 2;
    localparam int JW = $clog2(NWORDS);
    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    localparam logic [CW-1:0] CNT_INIT = CW'(MULT_LAT - 1);
    localparam logic [JW-1:0] J_LAST   = JW'(NWORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_W,
        CALC_X0,
        CALC_M,
        ACC,
        LAST,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] pp0_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] t_q;
    logic [XW-1:0]    x0_q;
    logic [WIDTH:0]   carry_q;
    logic [JW-1:0]    j_q;
    logic [CW-1:0]    cnt_q;

    logic             cnt_zero;
    logic [XW-1:0]    ab;
    logic [XW-1:0]    x0_calc;
    logic [WIDTH-1:0] m_calc;
    logic [XW-1:0]    xm_calc;
    logic [XW-1:0]    x_acc;
    logic             unused_msb;

    assign cnt_zero = (cnt_q == '0);

    // Operands are stable for the whole stage; result is taken on the
    // last cycle of the MULT_LAT-cycle window.
    assign ab      = XW'(a_q) * XW'(b_q);
    assign x0_calc = XW'(t_q) + ab;
    assign m_calc  = x0_q[WIDTH-1:0] * pp0_q;
    assign xm_calc = x0_q + XW'(m_calc) * XW'(p_q);
    assign x_acc   = XW'(t_q) + ab + XW'(m_q) * XW'(p_q) + XW'(carry_q);

    assign unused_msb = ^{xm_calc[XW-1], x_acc[XW-1]};

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_t_o     = '0;
        out_top_o   = 1'b0;
        done_o      = 1'b0;
        busy_o      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = WAIT_W;
                end
            end
            WAIT_W: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_next = (j_q == '0) ? CALC_X0 : ACC;
                end
            end
            CALC_X0: begin
                if (cnt_zero) begin
                    state_next = CALC_M;
                end
            end
            CALC_M: begin
                if (cnt_zero) begin
                    state_next = WAIT_W;
                end
            end
            ACC: begin
                if (cnt_zero) begin
                    out_valid_o = 1'b1;
                    out_t_o     = x_acc[WIDTH-1:0];
                    state_next  = (j_q < J_LAST) ? WAIT_W : LAST;
                end
            end
            LAST: begin
                out_valid_o = 1'b1;
                out_t_o     = carry_q[WIDTH-1:0];
                out_top_o   = carry_q[WIDTH];
                state_next  = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            j_q     <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            p_q     <= '0;
            t_q     <= '0;
            x0_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        j_q     <= '0;
                        carry_q <= '0;
                    end
                end
                WAIT_W: begin
                    if (in_valid_i) begin
                        b_q   <= in_b_i;
                        p_q   <= in_p_i;
                        t_q   <= in_t_i;
                        cnt_q <= CNT_INIT;
                    end
                end
                CALC_X0: begin
                    if (cnt_zero) begin
                        x0_q  <= x0_calc;
                        cnt_q <= CNT_INIT;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                CALC_M: begin
                    if (cnt_zero) begin
                        carry_q <= xm_calc[2*WIDTH:WIDTH];
                        j_q     <= JW'(1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ACC: begin
                    if (cnt_zero) begin
                        carry_q <= x_acc[2*WIDTH:WIDTH];
                        j_q     <= j_q + JW'(1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operand and quotient registers are always written before use.
    always_ff @(posedge clock_i) begin
        if (state == IDLE && start_i) begin
            a_q   <= a_i;
            pp0_q <= p_prime_0_i;
        end
        if (state == CALC_M && cnt_zero) begin
            m_q <= m_calc;
        end
    end

endmodule

// File: tb/tb_pe_fios_seq.sv
// Scoreboard bench for pe_fios_seq: two instances (2 words/lat 1 and
// 4 words/lat 3) share stimulus, selected by sel.
module tb_pe_fios_seq;

    localparam int W = 17;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    typedef struct packed {
        logic [W-1:0] t;
        logic         top;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] pp0;
    logic         valid;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic [W-1:0] t;
    logic         sel;

    logic         rdy0, ov0, top0, busy0, done0;
    logic [W-1:0] ot0;
    logic         rdy1, ov1, top1, busy1, done1;
    logic [W-1:0] ot1;
    logic         rdy, ov, top, busy, done;
    logic [W-1:0] ot;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovc = 0;
    bit last_d = 1'b0;

    exp_t sb[$];
    int   lat_q[$];

    logic [W-1:0] va, vpp;
    logic [W-1:0] vb[4];
    logic [W-1:0] vp[4];
    logic [W-1:0] vt[4];

    pe_fios_seq #(.WIDTH(W), .NWORDS(2), .MULT_LAT(1)) u_dut0 (
        .clock_i(clk), .reset_n_i(rst_n),
        .start_i(start & ~sel), .a_i(a), .p_prime_0_i(pp0),
        .in_valid_i(valid & ~sel), .in_ready_o(rdy0),
        .in_b_i(b), .in_p_i(p), .in_t_i(t),
        .out_valid_o(ov0), .out_t_o(ot0), .out_top_o(top0),
        .busy_o(busy0), .done_o(done0)
    );

    pe_fios_seq #(.WIDTH(W), .NWORDS(4), .MULT_LAT(3)) u_dut1 (
        .clock_i(clk), .reset_n_i(rst_n),
        .start_i(start & sel), .a_i(a), .p_prime_0_i(pp0),
        .in_valid_i(valid & sel), .in_ready_o(rdy1),
        .in_b_i(b), .in_p_i(p), .in_t_i(t),
        .out_valid_o(ov1), .out_t_o(ot1), .out_top_o(top1),
        .busy_o(busy1), .done_o(done1)
    );

    assign rdy  = sel ? rdy1  : rdy0;
    assign ov   = sel ? ov1   : ov0;
    assign ot   = sel ? ot1   : ot0;
    assign top  = sel ? top1  : top0;
    assign busy = sel ? busy1 : busy0;
    assign done = sel ? done1 : done0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   ec;
        bit   now_last;
        now_last = 1'b0;
        if (done) check("done_after_last", 64'(last_d), 64'd1);
        if (ov) begin
            ovc++;
            if (sb.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("out_t", 64'(ot), 64'(e.t));
                if (e.last) begin
                    check("out_top", 64'(top), 64'(e.top));
                    now_last = 1'b1;
                end else if (lat_q.size() == 0) begin
                    check("lat_missing", 64'd1, 64'd0);
                end else begin
                    ec = lat_q.pop_front();
                    check("latency", 64'(cyc), 64'(ec));
                end
            end
        end
        last_d = now_last;
    end

    task automatic clear_vec();
        va  = '0;
        vpp = '0;
        for (int j = 0; j < 4; j++) begin
            vb[j] = '0;
            vp[j] = '0;
            vt[j] = '0;
        end
    endtask

    task automatic rand_vec();
        va  = W'($urandom);
        vpp = W'($urandom);
        for (int j = 0; j < 4; j++) begin
            vb[j] = W'($urandom);
            vp[j] = W'($urandom);
            vt[j] = W'($urandom);
        end
    endtask

    task automatic max_vec();
        va  = '1;
        vpp = W'(1);
        for (int j = 0; j < 4; j++) begin
            vb[j] = '1;
            vp[j] = '1;
            vt[j] = '1;
        end
    endtask

    task automatic expect_iter(input int n);
        logic [63:0] x, m, c;
        x = 64'(vt[0]) + 64'(va) * 64'(vb[0]);
        m = ((x & MASK) * 64'(vpp)) & MASK;
        c = (x + m * 64'(vp[0])) >> W;
        for (int j = 1; j < n; j++) begin
            x = 64'(vt[j]) + 64'(va) * 64'(vb[j]) + m * 64'(vp[j]) + c;
            sb.push_back('{t: x[W-1:0], top: 1'b0, last: 1'b0});
            c = x >> W;
        end
        sb.push_back('{t: c[W-1:0], top: c[W], last: 1'b1});
    endtask

    task automatic do_start();
        start = 1'b1;
        a     = va;
        pp0   = vpp;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic drive_word(input int j, input int gap, input bit inj);
        int w;
        int lat;
        w   = 0;
        lat = sel ? 3 : 1;
        while (!rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!rdy) begin
            check("rdy_timeout", 64'd0, 64'd1);
            return;
        end
        for (int g = 0; g < gap; g++) begin
            check("stall_rdy", 64'(rdy), 64'd1);
            @(negedge clk);
        end
        valid = 1'b1;
        b     = vb[j];
        p     = vp[j];
        t     = vt[j];
        if (j > 0) lat_q.push_back(cyc + lat);
        @(negedge clk);
        if (inj) begin
            b     = ~vb[j];
            p     = ~vp[j];
            t     = ~vt[j];
            a     = ~va;
            start = 1'b1;
            check("rdy_low_busy", 64'(rdy), 64'd0);
            @(negedge clk);
            start = 1'b0;
        end
        valid = 1'b0;
    endtask

    task automatic run_iter(input int n, input int gap, input bit inj);
        int w;
        ovc = 0;
        do_start();
        for (int j = 0; j < n; j++) drive_word(j, (j > 0) ? gap : 0, inj);
        w = 0;
        while (!done && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", 64'(done), 64'd1);
        check("word_count", 64'(ovc), 64'(n));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("idle_after", 64'(busy), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_rdy"},  64'(rdy),  64'd0);
        check({tag, "_ov"},   64'(ov),   64'd0);
        check({tag, "_ot"},   64'(ot),   64'd0);
        check({tag, "_top"},  64'(top),  64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        a     = '0;
        pp0   = '0;
        b     = '0;
        p     = '0;
        t     = '0;
        sel   = 1'b0;
        clear_vec();
        repeat (3) @(negedge clk);
        reset_outputs("rst0");
        sel = 1'b1;
        #1;
        reset_outputs("rst1");
        sel = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        clear_vec();
        va = W'(1);
        vpp = W'(131071);
        vb[0] = W'(1);
        vp[0] = W'(1);
        sb.push_back('{t: W'(1), top: 1'b0, last: 1'b0});
        sb.push_back('{t: W'(0), top: 1'b0, last: 1'b1});
        run_iter(2, 0, 1'b0);

        clear_vec();
        vpp = W'(131071);
        vt[0] = W'(131071);
        vp[0] = W'(1);
        sb.push_back('{t: W'(1), top: 1'b0, last: 1'b0});
        sb.push_back('{t: W'(0), top: 1'b0, last: 1'b1});
        run_iter(2, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            rand_vec();
            expect_iter(2);
            run_iter(2, 0, 1'b0);
        end

        sel = 1'b1;
        @(negedge clk);
        max_vec();
        expect_iter(4);
        run_iter(4, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            rand_vec();
            expect_iter(4);
            run_iter(4, 0, 1'b0);
        end

        rand_vec();
        expect_iter(4);
        run_iter(4, 0, 1'b0);
        expect_iter(4);
        run_iter(4, 5, 1'b0);

        rand_vec();
        expect_iter(4);
        run_iter(4, 0, 1'b1);

        max_vec();
        expect_iter(4);
        do_start();
        drive_word(0, 0, 1'b0);
        drive_word(1, 0, 1'b0);
        check("acc_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        reset_outputs("midrst");
        sb.delete();
        lat_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        rand_vec();
        expect_iter(4);
        run_iter(4, 0, 1'b0);

        sel = 1'b0;
        @(negedge clk);
        rand_vec();
        expect_iter(2);
        run_iter(2, 3, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_fios_seq.md
PE_FIOS_SEQ -- requirements
Module: pe_fios_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 17, giving the word width of all operand and result words.
REQ-002 SHALL have parameter NWORDS, default 8, giving the words per operand; legal range 2..256.
REQ-003 SHALL have parameter MULT_LAT, default 3, giving the cycles per multiply-accumulate step; legal range 1..4.
REQ-004 clock_i  in  1  sole clock; all state on rising edge.
REQ-005 reset_n_i  in  1  synchronous, active-low reset.
REQ-006 start_i  in  1  begins one FIOS outer iteration; sampled only in IDLE.
REQ-007 a_i  in  WIDTH  multiplier word a_i; captured on accepted start.
REQ-008 p_prime_0_i  in  WIDTH  -p^-1 mod 2^WIDTH; captured on accepted start.
REQ-009 in_valid_i / in_ready_o  in/out  1  word handshake; transfer when both high.
REQ-010 in_b_i, in_p_i, in_t_i  in  WIDTH each  word j of b, modulus p, partial sum t.
REQ-011 out_valid_o  out  1  one-cycle pulse; no backpressure.
REQ-012 out_t_o  out  WIDTH  new partial-sum word.
REQ-013 out_top_o  out  1  bit WIDTH of the final carry; meaningful with the last out_valid_o.
REQ-014 busy_o, done_o  out  1  busy = not IDLE; done is a one-cycle pulse at iteration end.

Function
REQ-015 States SHALL be IDLE, WAIT_W, CALC_X0, CALC_M, ACC, LAST, DONE.
REQ-016 IDLE: start_i=1 SHALL capture a_i and p_prime_0_i, clear the word counter j and carry, and go to WAIT_W.
REQ-017 in_ready_o SHALL be 1 only in WAIT_W; a transfer SHALL register b, p and t, then go to CALC_X0 when j=0, else ACC.
REQ-018 CALC_X0: after MULT_LAT cycles, x0 = t0 + a*b0, then go to CALC_M.
REQ-019 CALC_M: after MULT_LAT cycles, m = (x0 mod 2^WIDTH)*p_prime_0 mod 2^WIDTH, carry = (x0 + m*p0) >> WIDTH, j=1, then go to WAIT_W; out_valid_o SHALL stay 0.
REQ-020 ACC (j>=1): after MULT_LAT cycles, x = t_j + a*b_j + m*p_j + carry.
  - out_t_o = x mod 2^WIDTH, emitted as t_{j-1} with out_valid_o=1 for that cycle.
  - carry = x >> WIDTH.
  - j increments; go to WAIT_W if j < NWORDS-1, else LAST.
REQ-021 LAST (1 cycle): out_valid_o=1, out_t_o = carry[WIDTH-1:0] (word t_{NWORDS-1}), out_top_o = carry[WIDTH]; then go to DONE.
REQ-022 DONE (1 cycle): done_o=1, then go to IDLE.
REQ-023 Arithmetic width rules:
  - intermediate x SHALL be 2*WIDTH+2 bits; carry SHALL be WIDTH+1 bits.
  - no truncation except the mod 2^WIDTH operations stated above.
REQ-024 Each stage SHALL take exactly MULT_LAT cycles, counted by an internal down-counter.
  - Latency from word-0 transfer to WAIT_W = 2*MULT_LAT cycles.
  - Latency from a word-j transfer (j>=1) to its out_valid_o = MULT_LAT cycles.
REQ-025 start_i while busy_o=1 SHALL be ignored; in_valid_i outside WAIT_W SHALL be ignored and consume no word.
REQ-026 Gaps in in_valid_i SHALL stall in WAIT_W indefinitely with no state change.
REQ-027 Exactly NWORDS out_valid_o pulses and one done_o pulse SHALL occur per iteration.

Reset
REQ-028 reset_n_i=0 at a clock edge SHALL force IDLE from any state, including mid-iteration, and clear j, carry and the stage counter.
REQ-029 Under reset, outputs SHALL be: in_ready_o=0, out_valid_o=0, out_t_o=0, out_top_o=0, busy_o=0, done_o=0.
REQ-030 Registers a, p_prime_0 and m SHALL need no reset; no output SHALL depend on them before the first accepted start.

Verification
REQ-031 Basic iteration: WIDTH=17, NWORDS=2, MULT_LAT=1, a=1, p'0=131071, b=[1,0], p=[1,0], t=[0,0] -> m=131071, outputs t0=1 then t1=0, out_top=0, done_o one cycle after the last word.
REQ-032 Wrap-around: a=0, p'0=131071, t=[131071,0], p=[1,0], b=[0,0] -> m=1, carry=1, outputs 1 then 0.
REQ-033 Maximum operands: NWORDS=4, MULT_LAT=3, all words 2^17-1, p'0=1 -> every output matches a bit-exact reference model, out_top_o checked, no overflow.
REQ-034 Stalls: in_valid_i deasserted for 5 cycles between words -> in_ready_o held high, outputs identical to the no-stall case, and latency per word unchanged at MULT_LAT.
REQ-035 Ignored inputs: start_i pulsed mid-iteration and in_valid_i asserted during ACC -> no effect on the iteration and no extra words consumed.
REQ-036 Reset mid-operation: reset_n_i=0 during ACC at j=1 -> next cycle busy_o=0 and all outputs 0; a fresh start then produces correct results.
